// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's data port.
// Word-organised local RAM with byte-lane steering for sub-word stores,
// aligned full-word loads and an optional fixed number of wait states.
//
// Optional feature macro: DMEM_RESPONDER_RANGE_CHECK_EN
//   defined   : addresses at or above 4*DEPTH_WORDS are out of range; stores
//               there are dropped, loads return 32'hDEADBEEF and O_fault is
//               set sticky until reset.
//   undefined : upper address bits are ignored (accesses alias modulo the
//               RAM size) and O_fault is tied low.
//
// FSM states:
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | ready; a request is performed at once when WAIT_STATES=0,
//           | otherwise it is captured and the wait countdown starts
//   ST_WAIT | stalling; counter runs down, captured access done at count 1

module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic [31:0] I_dmem_addr,
   input  logic [31:0] I_dmem_wdata,
   input  logic [3:0]  I_dmem_wmask,
   input  logic        I_dmem_rd,
   input  logic        I_dmem_we,
   output logic [31:0] O_dmem_rdata,
   output logic        O_stall,
   output logic        O_fault
);

   localparam int         AW     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_N = 4'(WAIT_STATES);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        r_stall;
   logic        w_stall_nxt;

   logic [31:0] r_cap_addr;
   logic [31:0] r_cap_wdata;
   logic [3:0]  r_cap_wmask;
   logic        r_cap_st;
   logic        r_cap_ld;

   logic [31:0] r_rdata;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_req;
   logic        w_capture;
   logic        w_acc_en;
   logic        w_acc_from_cap;

   logic [31:0] w_acc_addr;
   logic [31:0] w_acc_wdata;
   logic [3:0]  w_acc_wmask;
   logic        w_acc_st;
   logic        w_acc_ld;

   logic [1:0]    w_off;
   logic [7:0]    w_mask_wide;
   logic [3:0]    w_eff_mask;
   logic [63:0]   w_rot_wide;
   logic [31:0]   w_eff_wdata;
   logic [AW-1:0] w_idx;
   logic          w_oor;
   logic          w_wr_en;
   logic          w_rd_en;
   logic          w_unused_bits;

   // a store takes priority; rd alone is a load
   assign w_req = I_dmem_we | I_dmem_rd;

   // next-state, counter and stall decode
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_stall_nxt    = r_stall;
      w_capture      = 1'b0;
      w_acc_en       = 1'b0;
      w_acc_from_cap = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (WAIT_N == 4'd0) begin
                  w_acc_en = 1'b1;
               end else begin
                  w_capture   = 1'b1;
                  w_cnt_nxt   = WAIT_N;
                  w_state_nxt = ST_WAIT;
                  w_stall_nxt = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            // <= 1 rather than == 1 so a corrupted zero count cannot hang here
            if (r_cnt <= 4'd1) begin
               w_acc_en       = 1'b1;
               w_acc_from_cap = 1'b1;
               w_cnt_nxt      = 4'd0;
               w_state_nxt    = ST_IDLE;
               w_stall_nxt    = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
            w_stall_nxt = 1'b0;
         end
      endcase
   end

   // state, counter and stall registers
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_stall <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_stall <= w_stall_nxt;
      end
   end

   // capture the request that starts a wait so later inputs are ignored
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_cap_addr  <= 32'd0;
         r_cap_wdata <= 32'd0;
         r_cap_wmask <= 4'd0;
         r_cap_st    <= 1'b0;
         r_cap_ld    <= 1'b0;
      end else if (w_capture) begin
         r_cap_addr  <= I_dmem_addr;
         r_cap_wdata <= I_dmem_wdata;
         r_cap_wmask <= I_dmem_wmask;
         r_cap_st    <= I_dmem_we;
         r_cap_ld    <= I_dmem_rd & ~I_dmem_we;
      end
   end

   // select live or captured request for the access being performed
   always_comb begin
      w_acc_addr  = I_dmem_addr;
      w_acc_wdata = I_dmem_wdata;
      w_acc_wmask = I_dmem_wmask;
      w_acc_st    = I_dmem_we;
      w_acc_ld    = I_dmem_rd & ~I_dmem_we;
      if (w_acc_from_cap) begin
         w_acc_addr  = r_cap_addr;
         w_acc_wdata = r_cap_wdata;
         w_acc_wmask = r_cap_wmask;
         w_acc_st    = r_cap_st;
         w_acc_ld    = r_cap_ld;
      end
   end

   // lane steering: mask shifted up by the byte offset (bits past lane 3
   // fall off, so no word crossing), data rotated left by 8*offset
   assign w_off       = w_acc_addr[1:0];
   assign w_mask_wide = {4'b0000, w_acc_wmask} << w_off;
   assign w_eff_mask  = w_mask_wide[3:0];
   assign w_rot_wide  = {w_acc_wdata, w_acc_wdata} << {w_off, 3'b000};
   assign w_eff_wdata = w_rot_wide[63:32];
   assign w_idx       = w_acc_addr[AW+1:2];

`ifdef DMEM_RESPONDER_RANGE_CHECK_EN
   logic r_fault;

   assign w_oor         = |w_acc_addr[31:AW+2];
   assign w_unused_bits = ^{w_mask_wide[7:4], w_rot_wide[31:0]};

   // sticky out-of-range flag, set at the completing edge
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_fault <= 1'b0;
      end else if (w_acc_en && w_oor) begin
         r_fault <= 1'b1;
      end
   end

   assign O_fault = r_fault;
`else
   assign w_oor         = 1'b0;
   assign w_unused_bits = ^{w_mask_wide[7:4], w_rot_wide[31:0],
                            w_acc_addr[31:AW+2]};
   assign O_fault       = 1'b0;
`endif

   assign w_wr_en = w_acc_en & w_acc_st & ~w_oor;
   assign w_rd_en = w_acc_en & w_acc_ld;

   // RAM is never reset; only enabled byte lanes are written
   always_ff @(posedge I_clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (w_eff_mask[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_eff_wdata[8*b +: 8];
            end
         end
      end
   end

   // registered load data; holds on every cycle without a load
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_rdata <= 32'd0;
      end else if (w_rd_en) begin
         r_rdata <= w_oor ? 32'hDEADBEEF : r_mem[w_idx];
      end
   end

   assign O_dmem_rdata = r_rdata;
   assign O_stall      = r_stall;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one zero-wait instance and one three-wait
// instance, checked every cycle against a word-array model of the memory.
module tb_dmem_responder;

   localparam int D0 = 1024;
   localparam int D3 = 64;
   localparam int N3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] a0, wd0, a3, wd3;
   logic [3:0]  m0, m3;
   logic        rd0, we0, rd3, we3;
   logic [31:0] rdata0, rdata3;
   logic        stall0, stall3, fault0, fault3;

   dmem_responder #(.DEPTH_WORDS(D0), .WAIT_STATES(0)) u_dut0 (
      .I_clk(clk), .I_rst_n(rst_n), .I_dmem_addr(a0), .I_dmem_wdata(wd0),
      .I_dmem_wmask(m0), .I_dmem_rd(rd0), .I_dmem_we(we0),
      .O_dmem_rdata(rdata0), .O_stall(stall0), .O_fault(fault0));

   dmem_responder #(.DEPTH_WORDS(D3), .WAIT_STATES(N3)) u_dut3 (
      .I_clk(clk), .I_rst_n(rst_n), .I_dmem_addr(a3), .I_dmem_wdata(wd3),
      .I_dmem_wmask(m3), .I_dmem_rd(rd3), .I_dmem_we(we3),
      .O_dmem_rdata(rdata3), .O_stall(stall3), .O_fault(fault3));

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   logic [31:0] mem0 [int];
   logic [31:0] mem3 [int];
   logic [31:0] exp_rd0 = 32'd0;
   logic [31:0] exp_rd3 = 32'd0;
   logic        exp_st3 = 1'b0;
   logic        exp_f0  = 1'b0;
   logic        exp_f3  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] mask, input int off);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         int i;
         i = b - off;
         if (i >= 0 && mask[i]) res[8*b +: 8] = wd[8*i +: 8];
      end
      return res;
   endfunction

   // apply one completed access to the model of instance 0 or 3
   task automatic model_apply(input bit sel3, input logic we, input logic rd,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] mask);
      int depth;
      int idx;
      bit out;
      logic [31:0] old;
      depth = sel3 ? D3 : D0;
      idx   = int'((addr >> 2) % depth);
      out   = 1'b0;
`ifdef DMEM_RESPONDER_RANGE_CHECK_EN
      out = ({32'd0, addr} >= 64'(4 * depth));
`endif
      if (sel3) old = mem3.exists(idx) ? mem3[idx] : 32'd0;
      else      old = mem0.exists(idx) ? mem0[idx] : 32'd0;
      if (we || rd) begin
         if (out) begin
            if (sel3) exp_f3 = 1'b1; else exp_f0 = 1'b1;
         end
      end
      if (we) begin
         if (!out) begin
            if (sel3) mem3[idx] = merge(old, wd, mask, int'(addr[1:0]));
            else      mem0[idx] = merge(old, wd, mask, int'(addr[1:0]));
         end
      end else if (rd) begin
         if (sel3) exp_rd3 = out ? 32'hDEADBEEF : old;
         else      exp_rd0 = out ? 32'hDEADBEEF : old;
      end
   endtask

   task automatic model_reset();
      exp_rd0 = 32'd0;
      exp_rd3 = 32'd0;
      exp_st3 = 1'b0;
      exp_f0  = 1'b0;
      exp_f3  = 1'b0;
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      chk("rdata0", rdata0, exp_rd0);
      chk("stall0", 32'(stall0), 32'd0);
      chk("fault0", 32'(fault0), 32'(exp_f0));
      chk("rdata3", rdata3, exp_rd3);
      chk("stall3", 32'(stall3), 32'(exp_st3));
      chk("fault3", 32'(fault3), 32'(exp_f3));
   end

   // zero-wait request on instance 0, sampled at the next rising edge
   task automatic op0(input logic we, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] mask);
      @(negedge clk);
      we0 = we; rd0 = rd; a0 = addr; wd0 = wd; m0 = mask;
      @(posedge clk);
      #1;
      model_apply(1'b0, we, rd, addr, wd, mask);
      we0 = 1'b0; rd0 = 1'b0;
   endtask

   // wait-state request on instance 3; conflicting inputs driven during the
   // stall; optional async reset one edge into the wait
   task automatic op3(input logic we, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] mask, input bit abort);
      int hi;
      @(negedge clk);
      we3 = we; rd3 = rd; a3 = addr; wd3 = wd; m3 = mask;
      @(posedge clk);
      #1;
      exp_st3 = 1'b1;
      hi = int'(stall3);
      for (int j = 1; j <= N3; j++) begin
         @(negedge clk);
         we3 = 1'b1; rd3 = 1'b1; a3 = addr ^ 32'h4; wd3 = ~wd; m3 = 4'hF;
         @(posedge clk);
         #1;
         if (abort) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            we3 = 1'b0; rd3 = 1'b0;
            #1;
            chk("rst_stall3", 32'(stall3), 32'd0);
            chk("rst_rdata3", rdata3, 32'd0);
            chk("rst_fault3", 32'(fault3), 32'd0);
            chk("rst_rdata0", rdata0, 32'd0);
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (j == N3) begin
            model_apply(1'b1, we, rd, addr, wd, mask);
            exp_st3 = 1'b0;
         end
         hi += int'(stall3);
      end
      we3 = 1'b0; rd3 = 1'b0;
      chk("stall3_cycles", 32'(hi), 32'(N3));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a0 = 32'd0; wd0 = 32'd0; m0 = 4'd0; rd0 = 1'b0; we0 = 1'b0;
      a3 = 32'd0; wd3 = 32'd0; m3 = 4'd0; rd3 = 1'b0; we3 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset_rdata0", rdata0, 32'd0);
      chk("reset_stall3", 32'(stall3), 32'd0);

      // zero-wait instance: word store/load, sub-word stores, back to back
      op0(1, 0, 32'h10, 32'h11223344, 4'hF);
      op0(0, 1, 32'h10, 32'h0, 4'h0);
      chk("lw_0x10", rdata0, 32'h11223344);
      op0(1, 0, 32'h13, 32'h000000AB, 4'h1);
      op0(0, 1, 32'h10, 32'h0, 4'h0);
      chk("sb_0x13", rdata0, 32'hAB223344);
      op0(1, 0, 32'h12, 32'h0000BEEF, 4'h3);
      op0(0, 1, 32'h10, 32'h0, 4'h0);
      chk("sh_0x12", rdata0, 32'hBEEF3344);

      // we and rd together: store, rdata holds
      op0(1, 1, 32'h20, 32'hCAFEF00D, 4'hF);
      chk("we_rd_hold", rdata0, 32'hBEEF3344);
      op0(0, 1, 32'h20, 32'h0, 4'h0);
      chk("we_rd_store", rdata0, 32'hCAFEF00D);

      // halfword at offset 3: upper lane bit dropped, no word crossing
      op0(1, 0, 32'h23, 32'h00007766, 4'h3);
      op0(0, 1, 32'h20, 32'h0, 4'h0);
      chk("sh_off3", rdata0, 32'h66FEF00D);
      op0(0, 1, 32'h24, 32'h0, 4'h0);

      // range boundary on instance 0
      op0(1, 0, 32'h0, 32'h0BADF00D, 4'hF);
      op0(0, 1, 32'h1000, 32'h0, 4'h0);
`ifdef DMEM_RESPONDER_RANGE_CHECK_EN
      chk("range_rdata0", rdata0, 32'hDEADBEEF);
      chk("range_fault0", 32'(fault0), 32'd1);
`else
      chk("range_rdata0", rdata0, 32'h0BADF00D);
      chk("range_fault0", 32'(fault0), 32'd0);
`endif
      op0(0, 1, 32'h10, 32'h0, 4'h0);
      chk("after_range0", rdata0, 32'hBEEF3344);

      // three-wait instance
      op3(1, 0, 32'h10, 32'h11223344, 4'hF, 1'b0);
      op3(0, 1, 32'h10, 32'h0, 4'h0, 1'b0);
      chk("ws_lw_0x10", rdata3, 32'h11223344);
      op3(1, 0, 32'h30, 32'h12345678, 4'hF, 1'b0);
      op3(1, 0, 32'h0, 32'h0BADF00D, 4'hF, 1'b0);
      op3(0, 1, 32'h100, 32'h0, 4'h0, 1'b0);
`ifdef DMEM_RESPONDER_RANGE_CHECK_EN
      chk("range_rdata3", rdata3, 32'hDEADBEEF);
      chk("range_fault3", 32'(fault3), 32'd1);
`else
      chk("range_rdata3", rdata3, 32'h0BADF00D);
      chk("range_fault3", 32'(fault3), 32'd0);
`endif

      // reset in the middle of a waited store: store aborted, RAM retained
      op3(1, 0, 32'h30, 32'h00000055, 4'hF, 1'b1);
      op3(0, 1, 32'h30, 32'h0, 4'h0, 1'b0);
      chk("abort_keep_0x30", rdata3, 32'h12345678);
      op0(0, 1, 32'h10, 32'h0, 4'h0);
      chk("ram_kept_0x10", rdata0, 32'hBEEF3344);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core's data port. It accepts byte-addressed load and store requests, holds a word-organised local RAM and applies byte-lane write masks. It returns aligned read words and asserts `O_stall` while configurable wait states elapse. It sits directly on the core's data port (`dmem_addr`/`wdata`/`wmask`/`rd`/`we` in, `dmem_rdata`/`stall` out).

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; must be a power of two ≥ 4.
- `WAIT_STATES`, 0: extra cycles per access, range 0–15.
- `I_clk` input 1: clock, rising edge.
- `I_rst_n` input 1: one clock; reset is asynchronous and active-low.
- `I_dmem_addr` input 32: byte address.
- `I_dmem_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `I_dmem_wmask` input 4: right-aligned byte enables (0001 SB, 0011 SH, 1111 SW).
- `I_dmem_rd` input 1: load request.
- `I_dmem_we` input 1: store request.
- `O_dmem_rdata` output 32: aligned word read; the core rotates and extends it.
- `O_stall` output 1: responder busy; the core must hold its request.
- `O_fault` output 1: sticky out-of-range flag (see Configuration).

## Operation
- Word index = `addr[log2(DEPTH_WORDS)+1:2]`; byte offset `off = addr[1:0]`.
- Store lane steering:
  - Effective mask = `(wmask << off) & 4'hF`.
  - Effective data = `wdata` rotated left by `8*off`.
  - Only enabled bytes change; enable bits shifted past lane 3 are dropped (no word crossing).
- Load returns the full word at the index, unrotated.
- `we` and `rd` both high: the request is a store; `rd` is ignored and `O_dmem_rdata` holds its value.
- FSM has two states, IDLE and WAIT.
  - IDLE, request sampled, `WAIT_STATES`=0: the access is performed at that edge and the state stays IDLE.
  - IDLE, request sampled, `WAIT_STATES`=N>0: capture addr/wdata/mask/type, load counter with N, go to WAIT, `O_stall`=1.
  - WAIT: counter decrements each edge. At the edge where the counter equals 1, the captured access is performed, `O_stall`→0, and the state returns to IDLE.
  - WAIT: request inputs are ignored; only the captured request is used.
- Reset, including mid-WAIT:
  - State→IDLE, counter→0.
  - `O_stall`=0, `O_dmem_rdata`=0, `O_fault`=0.
  - RAM contents are not cleared; an aborted store is never written.

## Timing
- Request sampled at edge k, N=0: store visible at k; `O_dmem_rdata` valid after edge k (one-cycle load latency, matching the core's MEM-stage sample). `O_stall` never asserts.
- N>0: `O_stall` is high from after edge k through edge k+N, i.e. exactly N cycles. The access completes at edge k+N; load data is valid after k+N.
- The earliest next request is sampled at edge k+N+1.
- `O_dmem_rdata` holds its value on cycles with no load.
- All outputs are registered; there are no combinational input-to-output paths.
- Back-to-back requests in IDLE with N=0 are accepted every cycle. A load immediately after a store to the same word returns the new data.

## Configuration
- `DMEM_RESPONDER_RANGE_CHECK_EN` defined:
  - Addresses with `addr ≥ 4*DEPTH_WORDS` are out of range.
  - Out-of-range stores are dropped; out-of-range loads return 32'hDEADBEEF.
  - `O_fault` is set at the completing edge and stays set until reset.
  - Wait-state timing is unchanged.
- Macro undefined: upper address bits are ignored, so accesses alias modulo the RAM size, and `O_fault` is tied to 0.

## Test plan
- SW 0x11223344 at 0x10 (mask 1111), then LW 0x10 → rdata 0x11223344 one cycle after the load edge; `O_stall` stays 0.
- SB 0x000000AB at 0x13 (mask 0001), then SH 0x0000BEEF at 0x12 (mask 0011), then LW 0x10 → rdata 0xAB223344 after the SB and 0xBEEF3344 after the SH.
- `WAIT_STATES`=3, LW 0x10 at edge k → `O_stall` high for exactly 3 cycles; rdata 0x11223344 after edge k+3. Different inputs driven during the stall are ignored.
- `we`=`rd`=1, SW 0xCAFEF00D at 0x20 → word written; rdata unchanged from its previous value.
- Range check:
  - Macro defined, LW at 4*`DEPTH_WORDS` → rdata 0xDEADBEEF, `O_fault` 1 and sticky.
  - Macro undefined → rdata equals word 0, `O_fault` 0.
- `WAIT_STATES`=3, SW 0x55 at 0x30, `I_rst_n` low mid-WAIT → `O_stall`/`O_dmem_rdata`/`O_fault` go to 0 immediately; a later LW 0x30 shows the old contents.
